// File: rtl/pc_unit.sv
// Program counter with prioritised redirect/trap/call/return handling.
// Optional circular return-address stack enabled by defining PC_UNIT_RAS_EN.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call,
    input  logic [XLEN-1:0] call_target,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned,
    output logic            ras_underflow
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_reg, pc_next;
    logic            misaligned_reg, misaligned_next;
    logic            underflow_reg, underflow_next;
    logic            ras_has_entry;
    logic            ras_push, ras_pop, ras_flush;

    assign pc            = pc_reg;
    assign pc_plus4      = pc_reg + PC_STEP;
    assign misaligned    = misaligned_reg;
    assign ras_underflow = underflow_reg;

    always_comb begin
        pc_next         = pc_reg;
        misaligned_next = 1'b0;
        underflow_next  = 1'b0;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;
        ras_flush       = 1'b0;
        if (trap) begin
            pc_next   = TRAP_VECTOR;
            ras_flush = 1'b1;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (redirect_valid) begin
            pc_next         = {redirect_target[XLEN-1:2], 2'b00};
            misaligned_next = |redirect_target[1:0];
        end else if (ret) begin
            // Call is deliberately ignored when it coincides with ret.
            if (ras_has_entry) begin
                pc_next = ras_top;
                ras_pop = 1'b1;
            end else begin
                pc_next        = pc_plus4;
                underflow_next = 1'b1;
            end
        end else if (call) begin
            pc_next         = {call_target[XLEN-1:2], 2'b00};
            misaligned_next = |call_target[1:0];
            ras_push        = 1'b1;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg         <= RESET_VECTOR;
            misaligned_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            misaligned_reg <= misaligned_next;
            underflow_reg  <= underflow_next;
        end
    end

`ifdef PC_UNIT_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    // ras_ptr_reg is the slot the next push writes; the top lives one below it.
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr_reg, ras_ptr_next;
    logic [CW-1:0]   ras_count_reg, ras_count_next;
    logic            ras_empty_reg, ras_full_reg;
    logic [PW-1:0]   ras_top_idx;

    assign ras_top_idx   = ras_ptr_reg - PW'(1);
    assign ras_has_entry = (ras_count_reg != '0);
    assign ras_top       = ras_has_entry ? ras_mem[ras_top_idx] : '0;
    assign ras_empty     = ras_empty_reg;
    assign ras_full      = ras_full_reg;

    always_comb begin
        ras_ptr_next   = ras_ptr_reg;
        ras_count_next = ras_count_reg;
        if (ras_flush) begin
            ras_count_next = '0;
        end else if (ras_pop) begin
            ras_ptr_next   = ras_top_idx;
            ras_count_next = ras_count_reg - CW'(1);
        end else if (ras_push) begin
            // When full, the push lands on the oldest entry and count saturates.
            ras_ptr_next = ras_ptr_reg + PW'(1);
            if (ras_count_reg != CW'(RAS_DEPTH))
                ras_count_next = ras_count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_reg   <= '0;
            ras_count_reg <= '0;
            ras_empty_reg <= 1'b1;
            ras_full_reg  <= 1'b0;
        end else begin
            ras_ptr_reg   <= ras_ptr_next;
            ras_count_reg <= ras_count_next;
            ras_empty_reg <= (ras_count_next == '0);
            ras_full_reg  <= (ras_count_next == CW'(RAS_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push && !ras_flush && !ras_pop)
            ras_mem[ras_ptr_reg] <= pc_plus4;
    end
`else
    logic unused_ras;
    assign unused_ras    = ^{ras_push, ras_pop, ras_flush};
    assign ras_has_entry = 1'b0;
    assign ras_top       = '0;
    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model plus directed
// scenarios and randomized traffic with asynchronous reset pulses.
module tb_pc_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] TRAP  = 32'h0000_0100;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, trap, redirect_valid, call, ret;
    logic [31:0] redirect_target, call_target;
    logic [31:0] pc, pc_plus4, ras_top;
    logic        ras_empty, ras_full, misaligned, ras_underflow;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .call(call), .call_target(call_target), .ret(ret),
        .pc(pc), .pc_plus4(pc_plus4), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .misaligned(misaligned), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: the RAS is a plain queue, newest entry at the back.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_mis, m_uf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 32'h0; m_q.delete(); m_mis = 0; m_uf = 0;
        end else begin
            logic [31:0] p4;
            p4 = m_pc + 32'd4;
            m_mis = 0; m_uf = 0;
            if (trap) begin
                m_pc = TRAP; m_q.delete();
            end else if (stall) begin
                m_pc = m_pc;
            end else if (redirect_valid) begin
                m_pc = redirect_target & ~32'd3; m_mis = |redirect_target[1:0];
            end else if (ret) begin
                if (RAS_EN && m_q.size() > 0) m_pc = m_q.pop_back();
                else begin m_pc = p4; m_uf = 1; end
            end else if (call) begin
                if (RAS_EN) begin
                    m_q.push_back(p4);
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                end
                m_pc = call_target & ~32'd3; m_mis = |call_target[1:0];
            end else begin
                m_pc = p4;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("ras_top", ras_top, (m_q.size() == 0) ? 32'h0 : m_q[$]);
            check("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
            check("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
            check("misaligned", 32'(misaligned), 32'(m_mis));
            check("ras_underflow", 32'(ras_underflow), 32'(m_uf));
        end
    end

    // Inputs change at negedge+1; returns at the following negedge+1.
    task automatic drive(bit tr, bit st, bit rv, logic [31:0] rt,
                         bit ca, logic [31:0] ct, bit re);
        trap = tr; stall = st; redirect_valid = rv; redirect_target = rt;
        call = ca; call_target = ct; ret = re;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] prev, exp;
        rst = 1'b1;
        trap = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
        call = 0; call_target = 0; ret = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_pc", pc, 32'h0);
        check("rst_empty", 32'(ras_empty), 32'h1);
        check("rst_full", 32'(ras_full), 32'h0);
        check("rst_flags", {30'h0, misaligned, ras_underflow}, 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("seq_pc", pc, 32'(4 * i));
        end

        // Call then return.
        drive(0, 0, 1, 32'h40, 0, 0, 0);
        check("redir_40", pc, 32'h40);
        drive(0, 0, 0, 0, 1, 32'h200, 0);
        check("call_pc", pc, 32'h200);
        if (RAS_EN) check("call_top", ras_top, 32'h44);
        idle();
        check("after_call", pc, 32'h204);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("ret_pc", pc, RAS_EN ? 32'h44 : 32'h208);
        check("ret_empty", 32'(ras_empty), 32'h1);

        // Five nested calls, five returns.
        drive(0, 0, 1, 32'h600, 0, 0, 0);
        for (int i = 1; i <= 5; i++) drive(0, 0, 0, 0, 1, 32'(i * 32'h1000), 0);
        check("nest_full", 32'(ras_full), 32'(RAS_EN));
        prev = pc;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            exp = (RAS_EN && i < 4) ? 32'h4004 - 32'(i) * 32'h1000 : prev + 32'd4;
            check("nest_ret_pc", pc, exp);
            check("nest_uf", 32'(ras_underflow), 32'(!RAS_EN || i == 4));
            prev = exp;
        end
        idle();
        check("uf_pulse_end", 32'(ras_underflow), 32'h0);

        // Trap dominates stall and redirect; then stall holds.
        drive(0, 0, 0, 0, 1, 32'h700, 0);
        drive(1, 1, 1, 32'h80, 0, 0, 0);
        check("trap_pc", pc, 32'h100);
        check("trap_flush", 32'(ras_empty), 32'h1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            check("stall_pc", pc, 32'h100);
        end

        // Misaligned redirect pulse; call+ret acts as ret.
        drive(0, 0, 1, 32'h1002, 0, 0, 0);
        check("mis_pc", pc, 32'h1000);
        check("mis_hi", 32'(misaligned), 32'h1);
        idle();
        check("mis_lo", 32'(misaligned), 32'h0);
        drive(0, 0, 0, 0, 1, 32'h300, 0);
        drive(0, 0, 0, 0, 1, 32'h500, 1);
        check("callret_pc", pc, RAS_EN ? 32'h1008 : 32'h304);
        check("callret_empty", 32'(ras_empty), 32'h1);

        // Wrap-around.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        check("wrap_p4", pc_plus4, 32'h0);
        idle();
        check("wrap_pc", pc, 32'h0);
        check("wrap_mis", 32'(misaligned), 32'h0);

        // Mid-run asynchronous reset.
        drive(0, 0, 0, 0, 1, 32'h900, 0);
        rst = 1'b1;
        #2;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_empty", 32'(ras_empty), 32'h1);
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("post_rst_pc", pc, 32'(4 * i));
        end
        check("post_rst_empty", 32'(ras_empty), 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                idle();
                rst = 1'b0;
            end
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 3) == 0);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, 32, width of every address port and of the program counter.
REQ-002 Parameter RESET_VECTOR, 0, value loaded into pc on reset.
REQ-003 Parameter TRAP_VECTOR, 32'h0000_0100, value loaded into pc on trap.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hold pc and RAS unchanged this cycle.
REQ-008 trap  in  1  redirect to TRAP_VECTOR and flush the RAS.
REQ-009 redirect_valid  in  1  branch/jump taken; load redirect_target.
REQ-010 redirect_target  in  XLEN  branch/jump destination.
REQ-011 call  in  1  call instruction; jump to call_target and push the return address.
REQ-012 call_target  in  XLEN  call destination.
REQ-013 ret  in  1  return instruction; pop the RAS into pc.
REQ-014 pc  out  XLEN  current program counter, registered.
REQ-015 pc_plus4  out  XLEN  pc + 4, combinational, modulo 2^XLEN.
REQ-016 ras_top  out  XLEN  top RAS entry; 0 when empty.
REQ-017 ras_empty / ras_full  out  1 each  RAS occupancy flags, registered.
REQ-018 misaligned  out  1  one-cycle pulse: the loaded target had bits[1:0] != 0.
REQ-019 ras_underflow  out  1  one-cycle pulse: ret was accepted with the RAS empty.

Function
REQ-020 Next-pc priority, highest first: trap > stall > redirect_valid > ret > call > sequential (pc + 4).
REQ-021 Trap: pc <= TRAP_VECTOR; RAS occupancy <= 0; all other requests that cycle are ignored.
REQ-022 Stall without trap: pc, RAS contents, RAS occupancy and all flags hold; the misaligned and ras_underflow pulses go low.
REQ-023 Redirect: pc <= redirect_target with bits[1:0] forced to 0; misaligned <= |redirect_target[1:0]; the RAS is unchanged.
REQ-024 Ret, RAS non-empty: pc <= ras_top; occupancy decrements by 1.
REQ-025 Ret, RAS empty: pc <= pc + 4; ras_underflow pulses for one cycle.
REQ-026 Call: pc <= call_target with bits[1:0] forced to 0; pc + 4 is pushed; misaligned <= |call_target[1:0].
REQ-027 Call with RAS full: the push overwrites the oldest entry (circular buffer); occupancy stays RAS_DEPTH and ras_full stays 1.
REQ-028 Call and ret in the same cycle: ret wins and call is ignored.
REQ-029 Sequential: pc <= pc + 4; wraps from 2^XLEN - 4 to 0 without any flag.
REQ-030 misaligned and ras_underflow are registered, high for exactly one cycle per event, and low otherwise.
REQ-031 Latency: every request is visible on pc at the rising edge that samples it; there is no bubble.

Reset
REQ-032 While rst is high, regardless of clk: pc = RESET_VECTOR, RAS occupancy = 0, ras_empty = 1, ras_full = 0, misaligned = 0, ras_underflow = 0.
REQ-033 A reset asserted mid-operation discards all RAS contents; after rst deasserts, the first rising edge applies the REQ-020 priority from the reset state.

Configuration
REQ-034 Macro PC_UNIT_RAS_EN: when defined, the RAS is implemented per REQ-024..REQ-028.
REQ-035 When PC_UNIT_RAS_EN is undefined: no RAS storage exists; call is a plain jump to call_target; ret behaves per REQ-025 (pc + 4, ras_underflow pulse); ras_top = 0, ras_empty = 1, ras_full = 0 constantly.

Verification
REQ-036 rst pulse mid-run, then 3 idle cycles -> pc = 0, 4, 8, 12; ras_empty = 1.
REQ-037 At pc = 0x40, call to 0x200; at pc = 0x204, ret -> pc = 0x200, then 0x204, then 0x44; ras_empty = 1 after the ret.
REQ-038 5 nested calls with RAS_DEPTH = 4, then 5 rets -> the first 4 rets return the 4 newest addresses; the 5th ret gives pc + 4 with ras_underflow = 1 for one cycle.
REQ-039 Same cycle: stall = 1, trap = 1, redirect to 0x80 -> pc = 0x100 and RAS flushed; stall alone for 2 cycles -> pc held.
REQ-040 Redirect to 0x1002 -> pc = 0x1000 and misaligned = 1 for exactly one cycle; call and ret in the same cycle -> behaves as ret only.
REQ-041 With XLEN = 32, pc = 0xFFFF_FFFC and no request -> pc = 0x0000_0000 on the next edge.
